// File: rtl/top_pkg.sv
// top_pkg: shared constants, default parameters, parser states and saturating increment
package top_pkg;
  localparam int CLK_HZ_DEF   = 200000000;
  localparam int BAUD_DEF     = 115200;
  localparam int SPI_HALF_DEF = 10;
  localparam int GATE_DEF     = 200;
  localparam logic [7:0] CMD_MON = 8'h4D;
  localparam logic [7:0] CMD_SPI = 8'h53;
  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, SPI, REPLY} state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic e);
    return v + 8'(e && v != 8'hFF);
  endfunction
endpackage

// File: rtl/uart_phy.sv
// uart_phy: 8N1 UART receiver and transmitter, DIV clocks per bit
//   i_clk/i_rst : clock, async active-high reset
//   i_rx -> o_rx_data/o_rx_valid : received byte, one-cycle strobe, framing errors dropped
//   i_tx_data/i_tx_valid/o_tx_ready : byte accepted only when idle and i_cts=0
//   o_tx_busy : a byte is being shifted out; o_tx : serial line
module uart_phy #(
  parameter int DIV = 1736
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  input  logic       i_cts,
  output logic       o_tx
);
  localparam int CW = $clog2(DIV);
  logic [1:0] r_rx_s;
  logic r_rx_busy, r_rx_valid;
  logic [CW-1:0] r_rx_cnt, r_tx_cnt;
  logic [3:0] r_rx_bit, r_tx_bit;
  logic [7:0] r_rx_sh, r_rx_data;
  logic r_tx_busy;
  logic [9:0] r_tx_sh;
  assign o_rx_data = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_ready = !r_tx_busy && !i_cts;
  assign o_tx_busy = r_tx_busy;
  assign o_tx = r_tx_sh[0];
  // RX: first sample lands mid start bit, then every DIV clocks; a high start sample is a glitch
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rx_s <= 2'b11;
      r_rx_busy <= 1'b0;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh <= '0;
      r_rx_data <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_s <= {r_rx_s[0], i_rx};
      r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_s[1]) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt <= CW'(DIV / 2 - 1);
          r_rx_bit <= '0;
        end
      end else if (r_rx_cnt != '0) r_rx_cnt <= r_rx_cnt - 1'b1;
      else begin
        r_rx_cnt <= CW'(DIV - 1);
        r_rx_bit <= r_rx_bit + 1'b1;
        if (r_rx_bit == 4'd0 && r_rx_s[1]) r_rx_busy <= 1'b0;
        else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_valid <= r_rx_s[1];
          r_rx_data <= r_rx_sh;
        end else if (r_rx_bit != 4'd0) r_rx_sh <= {r_rx_s[1], r_rx_sh[7:1]};
      end
    end
  // TX: frame shifted out LSB first; ones shift in so the line idles high
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_tx_busy <= 1'b0;
      r_tx_sh <= '1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
    end else if (!r_tx_busy) begin
      if (i_tx_valid && !i_cts) begin
        r_tx_busy <= 1'b1;
        r_tx_sh <= {1'b1, i_tx_data, 1'b0};
        r_tx_cnt <= CW'(DIV - 1);
        r_tx_bit <= '0;
      end
    end else if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - 1'b1;
    else begin
      r_tx_cnt <= CW'(DIV - 1);
      r_tx_sh <= {1'b1, r_tx_sh[9:1]};
      r_tx_bit <= r_tx_bit + 1'b1;
      if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
    end
endmodule

// File: rtl/top.sv
// top: ADC link edge-rate monitor and SPI master driven by UART commands
//   clk200_p : clock (clk200_n unused); cpu_reset : async active-high reset
//   serial_rx/serial_tx : UART; serial_cts : transmit inhibit; serial_rts unused
//   LTC_SPI_cs_n/sclk/mosi/miso : ADC SPI master, mode 0
//   LTC_FR/OUT2_a/OUT2_b _p/_n : frame and lane inputs, only _p is used
module top
  import top_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int SPI_HALF = SPI_HALF_DEF,
  parameter int GATE     = GATE_DEF
) (
  input  logic clk200_p,
  input  logic clk200_n,
  input  logic cpu_reset,
  input  logic serial_rx,
  output logic serial_tx,
  input  logic serial_cts,
  input  logic serial_rts,
  output logic LTC_SPI_cs_n,
  output logic LTC_SPI_sclk,
  output logic LTC_SPI_mosi,
  input  logic LTC_SPI_miso,
  input  logic LTC_FR_p,
  input  logic LTC_FR_n,
  input  logic LTC_OUT2_a_p,
  input  logic LTC_OUT2_a_n,
  input  logic LTC_OUT2_b_p,
  input  logic LTC_OUT2_b_n
);
  localparam int WW = $clog2(GATE);
  localparam int SW = $clog2(SPI_HALF + 1);
  logic w_unused;
  logic [2:0] w_in, r_s1, r_s2, r_s3, w_rise;
  logic [WW-1:0] r_win;
  logic w_last;
  logic [2:0][7:0] r_cnt, r_lat, w_inc;
  logic [7:0] w_rx_data, r_hi, r_spi_rx;
  logic w_rx_valid, w_tx_valid, w_tx_ready, w_tx_busy, w_spi_go, w_spi_done;
  logic [23:0] r_rep;
  logic [1:0] r_rep_n;
  state_t r_state, w_state_n;
  logic r_cs_n, r_sclk, r_mosi;
  logic [14:0] r_spi_sh;
  logic [5:0] r_spi_ph;
  logic [SW-1:0] r_spi_cnt;
  assign w_unused = ^{clk200_n, serial_rts, LTC_FR_n, LTC_OUT2_a_n, LTC_OUT2_b_n};
  assign w_in = {LTC_OUT2_b_p, LTC_OUT2_a_p, LTC_FR_p};
  assign w_rise = r_s2 & ~r_s3;
  always_ff @(posedge clk200_p or posedge cpu_reset)
    if (cpu_reset) {r_s1, r_s2, r_s3} <= '0;
    else {r_s1, r_s2, r_s3} <= {w_in, r_s1, r_s2};
  // an edge seen in the last window cycle is folded into the latched count
  assign w_last = r_win == WW'(GATE - 1);
  for (genvar g = 0; g < 3; g++) begin : g_inc
    assign w_inc[g] = sat_inc(r_cnt[g], w_rise[g]);
  end
  always_ff @(posedge clk200_p or posedge cpu_reset)
    if (cpu_reset) begin
      r_win <= '0;
      r_cnt <= '0;
      r_lat <= '0;
    end else begin
      r_win <= w_last ? '0 : r_win + 1'b1;
      r_cnt <= w_last ? '0 : w_inc;
      if (w_last) r_lat <= w_inc;
    end
  uart_phy #(.DIV(CLK_HZ / BAUD)) u_phy (
    .i_clk(clk200_p),
    .i_rst(cpu_reset),
    .i_rx(serial_rx),
    .o_rx_data(w_rx_data),
    .o_rx_valid(w_rx_valid),
    .i_tx_data(r_rep[23:16]),
    .i_tx_valid(w_tx_valid),
    .o_tx_ready(w_tx_ready),
    .o_tx_busy(w_tx_busy),
    .i_cts(serial_cts),
    .o_tx(serial_tx)
  );
  // SPI runs in 33 half-period phases: even phases end with a rise, odd with a fall, the last raises cs_n
  assign w_spi_done = r_state == SPI && r_spi_cnt == '0 && r_spi_ph == 6'd32;
  always_ff @(posedge clk200_p or posedge cpu_reset)
    if (cpu_reset) begin
      r_state <= IDLE;
      r_hi <= '0;
      r_rep <= '0;
      r_rep_n <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE && w_rx_valid && w_rx_data == CMD_MON) begin
        r_rep <= {r_lat[0], r_lat[1], r_lat[2]};
        r_rep_n <= 2'd3;
      end else if (r_state == GET_HI && w_rx_valid) r_hi <= w_rx_data;
      else if (w_spi_done) begin
        r_rep <= {r_spi_rx, 16'h0};
        r_rep_n <= 2'd1;
      end else if (w_tx_valid && w_tx_ready) begin
        r_rep <= r_rep << 8;
        r_rep_n <= r_rep_n - 1'b1;
      end
    end
  // REPLY holds until the last byte has left the line, so bytes arriving meanwhile are dropped
  always_comb begin
    w_state_n = r_state;
    w_tx_valid = 1'b0;
    w_spi_go = 1'b0;
    case (r_state)
      IDLE: if (w_rx_valid) w_state_n = w_rx_data == CMD_MON ? REPLY : w_rx_data == CMD_SPI ? GET_HI : IDLE;
      GET_HI: if (w_rx_valid) w_state_n = GET_LO;
      GET_LO: if (w_rx_valid) begin
        w_state_n = SPI;
        w_spi_go = 1'b1;
      end
      SPI: if (w_spi_done) w_state_n = REPLY;
      REPLY: begin
        w_tx_valid = r_rep_n != 2'd0;
        if (r_rep_n == 2'd0 && !w_tx_busy) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk200_p or posedge cpu_reset)
    if (cpu_reset) begin
      r_cs_n <= 1'b1;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_spi_sh <= '0;
      r_spi_rx <= '0;
      r_spi_ph <= '0;
      r_spi_cnt <= '0;
    end else if (w_spi_go) begin
      r_cs_n <= 1'b0;
      r_mosi <= r_hi[7];
      r_spi_sh <= {r_hi[6:0], w_rx_data};
      r_spi_ph <= '0;
      r_spi_cnt <= SW'(SPI_HALF - 1);
    end else if (r_state == SPI) begin
      if (r_spi_cnt != '0) r_spi_cnt <= r_spi_cnt - 1'b1;
      else begin
        r_spi_cnt <= SW'(SPI_HALF - 1);
        r_spi_ph <= r_spi_ph + 1'b1;
        if (w_spi_done) begin
          r_cs_n <= 1'b1;
          r_mosi <= 1'b0;
        end else if (!r_spi_ph[0]) begin
          r_sclk <= 1'b1;
          r_spi_rx <= {r_spi_rx[6:0], LTC_SPI_miso};
        end else begin
          r_sclk <= 1'b0;
          r_spi_sh <= r_spi_sh << 1;
          if (r_spi_ph != 6'd31) r_mosi <= r_spi_sh[14];
        end
      end
    end
  assign LTC_SPI_cs_n = r_cs_n;
  assign LTC_SPI_sclk = r_sclk;
  assign LTC_SPI_mosi = r_mosi;
endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench for top with a fast-baud instance and a default-baud timing instance
module tb_top;
  localparam int BIT = 16;
  localparam int BIT_DEF = 1736;
  logic clk = 1'b0;
  logic cpu_reset = 1'b1, serial_rx = 1'b1, serial_cts = 1'b0, miso = 1'b0;
  logic serial_tx, cs_n, sclk, mosi;
  logic rst2 = 1'b1, rx2 = 1'b1;
  logic tx2, cs2, sclk2, mosi2;
  logic fr, lane_a;
  int ph = 0;
  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  always @(negedge clk) ph <= ph + 1;
  assign fr = (ph % 40) < 20;
  assign lane_a = (ph % 200) < 100;
  top #(.CLK_HZ(200000000), .BAUD(12500000), .SPI_HALF(10), .GATE(200)) u_dut (
    .clk200_p(clk), .clk200_n(~clk), .cpu_reset(cpu_reset),
    .serial_rx(serial_rx), .serial_tx(serial_tx), .serial_cts(serial_cts), .serial_rts(1'b0),
    .LTC_SPI_cs_n(cs_n), .LTC_SPI_sclk(sclk), .LTC_SPI_mosi(mosi), .LTC_SPI_miso(miso),
    .LTC_FR_p(fr), .LTC_FR_n(~fr), .LTC_OUT2_a_p(lane_a), .LTC_OUT2_a_n(~lane_a),
    .LTC_OUT2_b_p(1'b0), .LTC_OUT2_b_n(1'b1)
  );
  top u_dut2 (
    .clk200_p(clk), .clk200_n(~clk), .cpu_reset(rst2),
    .serial_rx(rx2), .serial_tx(tx2), .serial_cts(1'b0), .serial_rts(1'b0),
    .LTC_SPI_cs_n(cs2), .LTC_SPI_sclk(sclk2), .LTC_SPI_mosi(mosi2), .LTC_SPI_miso(1'b0),
    .LTC_FR_p(fr), .LTC_FR_n(~fr), .LTC_OUT2_a_p(lane_a), .LTC_OUT2_a_n(~lane_a),
    .LTC_OUT2_b_p(1'b0), .LTC_OUT2_b_n(1'b1)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  // UART monitor: decodes every byte on serial_tx and scores it against the queue
  logic [7:0] mon_b;
  initial forever begin
    @(negedge clk);
    if (serial_tx === 1'b0) begin
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        mon_b[i] = serial_tx;
      end
      repeat (BIT) @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_byte: got %0h required none", mon_b);
      end else check("reply_byte", {24'h0, mon_b}, {24'h0, exp_q.pop_front()});
    end
  end
  // SPI monitor: pulse count, MOSI at each rise, gap from cs_n fall / previous rise
  int spi_rises = 0, spi_gap = 0, spi_gap_err = 0;
  logic [15:0] spi_mosi = '0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1;
  always @(negedge clk) begin
    spi_gap = spi_gap + 1;
    if (prev_cs && !cs_n) begin
      spi_rises = 0;
      spi_gap = 0;
      spi_gap_err = 0;
    end
    if (!prev_sclk && sclk) begin
      if (spi_gap != (spi_rises == 0 ? 10 : 20)) spi_gap_err = spi_gap_err + 1;
      spi_gap = 0;
      spi_rises = spi_rises + 1;
      spi_mosi = {spi_mosi[14:0], mosi};
    end
    prev_sclk = sclk;
    prev_cs = cs_n;
  end
  int cts_viol = 0;
  always @(negedge clk) if (serial_cts && !serial_tx) cts_viol <= cts_viol + 1;
  task automatic send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_rx = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask
  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask
  // default-baud instance: start bit of the first reply byte (0x05, bit0=1) must span one full bit
  logic done2 = 1'b0;
  initial begin
    logic [9:0] f;
    int t, len;
    f = {1'b1, 8'h4D, 1'b0};
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rx2 = f[i];
      repeat (BIT_DEF) @(negedge clk);
    end
    rx2 = 1'b1;
    t = 0;
    while (tx2 === 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    len = 0;
    while (tx2 === 1'b0 && len < 4000) begin
      len++;
      @(negedge clk);
    end
    check("start_bit_len", len, BIT_DEF);
    done2 = 1'b1;
  end
  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_tx", serial_tx, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    cpu_reset = 1'b0;
    repeat (500) @(negedge clk);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    send(8'h4D);
    wait_empty("mon_drain");
    miso = 1'b1;
    exp_q.push_back(8'hFF);
    send(8'h53);
    send(8'h80);
    send(8'h01);
    wait_empty("spi_drain");
    check("spi_pulses", spi_rises, 16);
    check("spi_mosi_bits", {16'h0, spi_mosi}, 32'h8001);
    check("spi_sclk_timing_errs", spi_gap_err, 0);
    check("spi_cs_n_idle", cs_n, 1);
    serial_cts = 1'b1;
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    send(8'h4D);
    repeat (30 * BIT) @(negedge clk);
    check("cts_tx_low_cycles", cts_viol, 0);
    check("cts_held_bytes", exp_q.size(), 3);
    serial_cts = 1'b0;
    wait_empty("cts_drain");
    send(8'h41);
    repeat (20 * BIT) @(negedge clk);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    send(8'h4D);
    wait_empty("after_41_drain");
    miso = 1'b0;
    send(8'h53);
    send(8'h12);
    send(8'h34);
    t = 0;
    while (!(spi_rises == 5 && sclk === 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("mid_spi_pulses", spi_rises, 5);
    cpu_reset = 1'b1;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_sclk", sclk, 0);
    repeat (3) @(negedge clk);
    cpu_reset = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    check("post_rst_pulses", spi_rises, 5);
    check("post_rst_queue", exp_q.size(), 0);
    t = 0;
    while (!done2 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    check("default_baud_done", done2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
